// File: rtl/mult_seq_param_if.sv
// Operand/result bundle for mult_seq_param: start strobe, operands and sign mode in,
// busy/ready flags and product out.
interface mult_seq_param_if #(
  parameter int WIDTH = 16
);
  logic                 din_rdy;
  logic [WIDTH-1:0]     din_a;
  logic [WIDTH-1:0]     din_b;
  logic                 signed_mode;
  logic                 busy;
  logic                 dout_rdy;
  logic [2*WIDTH-1:0]   dout;

  modport master (
    output din_rdy, din_a, din_b, signed_mode,
    input  busy, dout_rdy, dout
  );

  modport slave (
    input  din_rdy, din_a, din_b, signed_mode,
    output busy, dout_rdy, dout
  );
endinterface

// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier, one multiplier bit per clock with early exit on B == 0.
// Define MULT_SIGNED_EN to build two's-complement support selected by signed_mode.
module mult_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  mult_seq_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    dout_q, dout_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             dout_rdy_q, dout_rdy_d;
  logic             neg_q, neg_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_in;
  logic [PW-1:0]    result;

`ifdef MULT_SIGNED_EN
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign mag_a  = mag(bus.din_a, bus.signed_mode);
  assign mag_b  = mag(bus.din_b, bus.signed_mode);
  assign neg_in = bus.signed_mode & (bus.din_a[WIDTH-1] ^ bus.din_b[WIDTH-1]);
  assign result = apply_sign(p_q, neg_q);
`else
  logic [1:0] unused_cfg;

  assign mag_a      = bus.din_a;
  assign mag_b      = bus.din_b;
  assign neg_in     = 1'b0;
  assign result     = p_q;
  assign unused_cfg = {bus.signed_mode, neg_q};
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    neg_d      = neg_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    dout_rdy_d = dout_rdy_q;
    case (state_q)
      IDLE: begin
        if (bus.din_rdy) begin
          a_d     = {{WIDTH{1'b0}}, mag_a};
          b_d     = mag_b;
          p_d     = '0;
          neg_d   = neg_in;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (b_q != '0) begin
          if (b_q[0]) p_d = p_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else begin
          dout_d     = result;
          dout_rdy_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        dout_rdy_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      neg_q      <= 1'b0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      dout_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      neg_q      <= neg_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      dout_rdy_q <= dout_rdy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.dout_rdy = dout_rdy_q;
  assign bus.dout     = dout_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param (WIDTH=16): vector table plus ignore-while-busy and
// mid-run reset sequences. Signed expectations follow MULT_SIGNED_EN.
module tb_mult_seq_param;
  localparam int WIDTH = 16;

`ifdef MULT_SIGNED_EN
  localparam logic [31:0] E3 = 32'hFFFF_FFEB;  localparam int L3 = 5;
  localparam logic [31:0] E6 = 32'h0000_0003;  localparam int L6 = 3;
  localparam logic [31:0] E7 = 32'hFFFF_FFEB;  localparam int L7 = 4;
`else
  localparam logic [31:0] E3 = 32'h0006_FFEB;  localparam int L3 = 5;
  localparam logic [31:0] E6 = 32'hFFFC_0003;  localparam int L6 = 18;
  localparam logic [31:0] E7 = 32'h0006_FFEB;  localparam int L7 = 18;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_seq_param_if #(.WIDTH(WIDTH)) bus_i ();
  mult_seq_param #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus_i));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] exp_p;
    int          exp_edges;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle; counts edges with the accept edge as 1.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sm, input logic [31:0] exp_p, input int exp_edges);
    logic [31:0] prev;
    int          edges;
    bit          seen;
    bit          stable;
    prev   = bus_i.dout;
    stable = 1'b1;
    seen   = 1'b0;
    edges  = 1;
    bus_i.din_a       = a;
    bus_i.din_b       = b;
    bus_i.signed_mode = sm;
    bus_i.din_rdy     = 1'b1;
    @(posedge clk); #1;
    bus_i.din_rdy = 1'b0;
    check({name, " busy_after_accept"}, 64'(bus_i.busy), 64'd1);
    while (!seen && edges < 40) begin
      if (bus_i.dout !== prev) stable = 1'b0;
      @(posedge clk); #1;
      edges++;
      seen = (bus_i.dout_rdy === 1'b1);
    end
    check({name, " latency"}, 64'(edges), 64'(exp_edges));
    check({name, " dout"}, 64'(bus_i.dout), 64'(exp_p));
    check({name, " dout_stable_before"}, 64'(stable), 64'd1);
    @(posedge clk); #1;
    check({name, " single_pulse"}, 64'(bus_i.dout_rdy), 64'd0);
    check({name, " busy_low"}, 64'(bus_i.busy), 64'd0);
    check({name, " dout_hold"}, 64'(bus_i.dout), 64'(exp_p));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int edges;
    int pulses;
    int first_edge;

    rst               = 1'b0;
    bus_i.din_rdy     = 1'b0;
    bus_i.din_a       = '0;
    bus_i.din_b       = '0;
    bus_i.signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus_i.busy), 64'd0);
    check("reset dout_rdy", 64'(bus_i.dout_rdy), 64'd0);
    check("reset dout", 64'(bus_i.dout), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 5};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 18};
    vecs[2] = '{16'h1234, 16'h0000, 1'b0, 32'h0000_0000, 2};
    vecs[3] = '{16'hFFFD, 16'h0007, 1'b1, E3, L3};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 18};
    vecs[5] = '{16'h0001, 16'h8000, 1'b0, 32'h0000_8000, 18};
    vecs[6] = '{16'hFFFD, 16'hFFFF, 1'b1, E6, L6};
    vecs[7] = '{16'h0007, 16'hFFFD, 1'b1, E7, L7};
    vecs[8] = '{16'h00FF, 16'h0100, 1'b0, 32'h0000_FF00, 11};

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
             vecs[i].exp_p, vecs[i].exp_edges);
    end

    // Strobe held with other operands through RUN and DONE; dropped once back in IDLE.
    bus_i.din_a       = 16'h0003;
    bus_i.din_b       = 16'h0005;
    bus_i.signed_mode = 1'b0;
    bus_i.din_rdy     = 1'b1;
    @(posedge clk); #1;
    bus_i.din_a = 16'hFFFF;
    bus_i.din_b = 16'hFFFF;
    edges       = 1;
    pulses      = 0;
    first_edge  = 0;
    while (edges < 12) begin
      @(posedge clk); #1;
      edges++;
      if (bus_i.dout_rdy === 1'b1) begin
        pulses++;
        if (first_edge == 0) first_edge = edges;
      end
      if (bus_i.busy === 1'b0) bus_i.din_rdy = 1'b0;
    end
    bus_i.din_rdy = 1'b0;
    check("ignore pulses", 64'(pulses), 64'd1);
    check("ignore latency", 64'(first_edge), 64'd5);
    check("ignore dout", 64'(bus_i.dout), 64'h0000_000F);
    check("ignore busy_low", 64'(bus_i.busy), 64'd0);

    // Reset five cycles into a long multiply.
    bus_i.din_a   = 16'hFFFF;
    bus_i.din_b   = 16'hFFFF;
    bus_i.din_rdy = 1'b1;
    @(posedge clk); #1;
    bus_i.din_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun busy", 64'(bus_i.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("rst busy", 64'(bus_i.busy), 64'd0);
    check("rst dout", 64'(bus_i.dout), 64'd0);
    check("rst dout_rdy", 64'(bus_i.dout_rdy), 64'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus_i.dout_rdy === 1'b1) pulses++;
    end
    check("rst no_pulse", 64'(pulses), 64'd0);
    check("rst stays_idle", 64'(bus_i.busy), 64'd0);
    run_op("after_rst", 16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
